qsystd_pwm_gen: RTL

Avalon-MM slave PWM generator: shared prescaler and period counter, NCH per-channel duty comparators with double-buffered (shadow) period/duty registers. It drives the PWM pins and the PWM status lines sampled by the status input PIO. That PIO edge-captures and raises an IRQ on these levels, so every output here is glitch-free and registered.

---
 rtl/qsystd_pwm_pkg.sv | 15 +
 rtl/qsystd_pwm_chan.sv | 43 ++++
 rtl/qsystd_pwm_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/qsystd_pwm_pkg.sv
// Shared constants for the qsystd PWM generator: register map, CTRL bit positions,
// default counter width.
package qsystd_pwm_pkg;

  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_PRESCALE = 1;
  localparam int unsigned ADDR_PERIOD   = 2;
  localparam int unsigned ADDR_STATUS   = 3;
  localparam int unsigned ADDR_DUTY0    = 4;

  localparam int unsigned RUN_BIT       = 8;

  localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/qsystd_pwm_chan.sv
// One PWM channel: duty shadow, active duty loaded on wrap or while stopped, and a
// registered enable-gated comparator.
module qsystd_pwm_chan
  import qsystd_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             duty_we,
  input  logic [CNT_W-1:0] wdata,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] duty_sh,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_sh_q;
  logic [CNT_W-1:0] duty_act_q;
  logic             pwm_q;

  // A load in the same clock as a shadow write picks up the pre-write shadow value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      if (duty_we) begin
        duty_sh_q <= wdata;
      end
      if (load) begin
        duty_act_q <= duty_sh_q;
      end
      pwm_q <= en & (cnt < duty_act_q);
    end
  end

  assign duty_sh = duty_sh_q;
  assign pwm     = pwm_q;

endmodule

// File: rtl/qsystd_pwm_gen.sv
// Avalon-MM PWM generator: bus decode, read mux, shared prescaler and period counter,
// period shadow/active and wrap pulse; per-channel compare lives in qsystd_pwm_chan.
module qsystd_pwm_gen
  import qsystd_pwm_pkg::*;
#(
  parameter int unsigned NCH   = 8,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [3:0]     address,
  input  logic           chipselect,
  input  logic           write_n,
  input  logic [31:0]    writedata,
  output logic [31:0]    readdata,
  output logic [NCH-1:0] pwm_out,
  output logic           wrap
);

  logic             wr_en;
  logic [CNT_W-1:0] wdata;
  logic             unused_wdata;

  logic [NCH-1:0]   en_q;
  logic             run_q;
  logic [CNT_W-1:0] prescale_q;
  logic [CNT_W-1:0] period_sh_q;
  logic [CNT_W-1:0] period_act_q;
  logic [CNT_W-1:0] pre_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wrap_q;
  logic [31:0]      rdata_d;
  logic [31:0]      rdata_q;

  logic             tick;
  logic             at_end;
  logic             load;
  logic [CNT_W-1:0] duty_sh [NCH];

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[CNT_W-1:0];
  assign unused_wdata = ^writedata;

  assign tick   = run_q && (pre_cnt_q == prescale_q);
  assign at_end = (cnt_q == period_act_q);
  // While stopped the active registers track the shadows every clock.
  assign load   = !run_q || (tick && at_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q        <= '0;
      run_q       <= 1'b0;
      prescale_q  <= '0;
      period_sh_q <= '0;
    end else if (wr_en) begin
      case (address)
        4'(ADDR_CTRL): begin
          en_q  <= writedata[NCH-1:0];
          run_q <= writedata[RUN_BIT];
        end
        4'(ADDR_PRESCALE): prescale_q  <= wdata;
        4'(ADDR_PERIOD):   period_sh_q <= wdata;
        default: ;
      endcase
    end
  end

  // Prescaler wraps through 2^CNT_W if PRESCALE is lowered below the current count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q    <= '0;
      cnt_q        <= '0;
      period_act_q <= '0;
      wrap_q       <= 1'b0;
    end else begin
      if (!run_q || tick) begin
        pre_cnt_q <= '0;
      end else begin
        pre_cnt_q <= pre_cnt_q + CNT_W'(1);
      end

      if (!run_q) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= at_end ? '0 : cnt_q + CNT_W'(1);
      end

      if (load) begin
        period_act_q <= period_sh_q;
      end

      wrap_q <= run_q & tick & at_end;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      4'(ADDR_CTRL): begin
        rdata_d[NCH-1:0] = en_q;
        rdata_d[RUN_BIT] = run_q;
      end
      4'(ADDR_PRESCALE): rdata_d[CNT_W-1:0] = prescale_q;
      4'(ADDR_PERIOD):   rdata_d[CNT_W-1:0] = period_sh_q;
      4'(ADDR_STATUS):   rdata_d[CNT_W-1:0] = cnt_q;
      default: begin
        for (int i = 0; i < int'(NCH); i++) begin
          if (address == 4'(ADDR_DUTY0 + i)) begin
            rdata_d[CNT_W-1:0] = duty_sh[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
    qsystd_pwm_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .duty_we (wr_en && (address == 4'(ADDR_DUTY0 + g))),
      .wdata   (wdata),
      .load    (load),
      .en      (en_q[g]),
      .cnt     (cnt_q),
      .duty_sh (duty_sh[g]),
      .pwm     (pwm_out[g])
    );
  end

  assign readdata = rdata_q;
  assign wrap     = wrap_q;

endmodule
